// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/memory handshake in, datapath control strobes out.
interface multicycle_control_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;

    modport master (
        output op, mem_ready,
        input  pc_write, branch_eq, branch_ne, iord, mem_read, mem_write, ir_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal
    );

    modport slave (
        input  op, mem_ready,
        output pc_write, branch_eq, branch_ne, iord, mem_read, mem_write, ir_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS-subset control FSM; define MC_JAL_EN to add JAL support.
module multicycle_control (
    input  logic                clk,
    input  logic                reset,
    multicycle_control_if.slave ctl
);
`ifdef MC_JAL_EN
    localparam logic JalEn = 1'b1;
`else
    localparam logic JalEn = 1'b0;
`endif

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXE, RWB, IEXE, IWB, BR, JMP, JAL
    } stateT;

    stateT      state;
    stateT      decodeNext;
    logic [2:0] immAluOp;

    always_comb begin
        decodeNext = (ctl.op == 6'h23 || ctl.op == 6'h2b) ? MEMADR :
                     (ctl.op == 6'h00) ? REXE :
                     (ctl.op == 6'h08 || ctl.op == 6'h0d || ctl.op == 6'h0f) ? IEXE :
                     (ctl.op == 6'h04 || ctl.op == 6'h05) ? BR :
                     (ctl.op == 6'h02) ? JMP :
                     (ctl.op == 6'h03 && JalEn) ? JAL : FETCH;
        immAluOp = ctl.op == 6'h08 ? 3'b100 : ctl.op == 6'h0d ? 3'b001 : 3'b101;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= FETCH;
        else
            case (state)
                FETCH:   if (ctl.mem_ready) state <= DECODE;
                DECODE:  state <= decodeNext;
                MEMADR:  state <= ctl.op == 6'h23 ? MEMRD : MEMWR;
                MEMRD:   if (ctl.mem_ready) state <= MEMWB;
                MEMWR:   if (ctl.mem_ready) state <= FETCH;
                REXE:    state <= RWB;
                IEXE:    state <= IWB;
                default: state <= FETCH;
            endcase
    end

    // Reset gates every strobe combinationally so a write in flight drops immediately.
    always_comb begin
        ctl.pc_write   = 1'b0;
        ctl.branch_eq  = 1'b0;
        ctl.branch_ne  = 1'b0;
        ctl.iord       = 1'b0;
        ctl.mem_read   = 1'b0;
        ctl.mem_write  = 1'b0;
        ctl.ir_write   = 1'b0;
        ctl.reg_write  = 1'b0;
        ctl.reg_dst    = 2'b00;
        ctl.mem_to_reg = 2'b00;
        ctl.alu_src_a  = 1'b0;
        ctl.alu_src_b  = 2'b00;
        ctl.alu_op     = 3'b000;
        ctl.pc_source  = 2'b00;
        ctl.illegal    = 1'b0;
        if (!reset)
            case (state)
                FETCH: begin
                    ctl.mem_read  = 1'b1;
                    ctl.alu_src_b = 2'b01;
                    ctl.alu_op    = 3'b011;
                    ctl.ir_write  = ctl.mem_ready;
                    ctl.pc_write  = ctl.mem_ready;
                end
                DECODE: begin
                    ctl.alu_src_b = 2'b11;
                    ctl.alu_op    = 3'b011;
                    ctl.illegal   = decodeNext == FETCH;
                end
                MEMADR: begin
                    ctl.alu_src_a = 1'b1;
                    ctl.alu_src_b = 2'b10;
                    ctl.alu_op    = 3'b011;
                end
                MEMRD: begin
                    ctl.mem_read = 1'b1;
                    ctl.iord     = 1'b1;
                end
                MEMWB: begin
                    ctl.reg_write  = 1'b1;
                    ctl.mem_to_reg = 2'b01;
                end
                MEMWR: begin
                    ctl.mem_write = 1'b1;
                    ctl.iord      = 1'b1;
                end
                REXE: begin
                    ctl.alu_src_a = 1'b1;
                    ctl.alu_op    = 3'b111;
                end
                RWB: begin
                    ctl.reg_write = 1'b1;
                    ctl.reg_dst   = 2'b01;
                end
                IEXE, IWB: begin
                    ctl.alu_src_a = 1'b1;
                    ctl.alu_src_b = 2'b10;
                    ctl.alu_op    = immAluOp;
                    ctl.reg_write = state == IWB;
                end
                BR: begin
                    ctl.alu_src_a = 1'b1;
                    ctl.alu_op    = 3'b010;
                    ctl.pc_source = 2'b01;
                    ctl.branch_eq = ctl.op == 6'h04;
                    ctl.branch_ne = ctl.op == 6'h05;
                end
                JMP, JAL: begin
                    ctl.pc_write   = 1'b1;
                    ctl.pc_source  = 2'b10;
                    ctl.reg_write  = state == JAL && JalEn;
                    ctl.reg_dst    = (state == JAL && JalEn) ? 2'b10 : 2'b00;
                    ctl.mem_to_reg = (state == JAL && JalEn) ? 2'b10 : 2'b00;
                end
                default: ;
            endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench; driver queues per-cycle expected strobes, monitor checks them.
module tb_multicycle_control;
    logic clk = 1'b1;
    logic reset;
    multicycle_control_if bus();

    multicycle_control dut (.clk(clk), .reset(reset), .ctl(bus));

    always #5 clk = ~clk;

    function automatic logic [20:0] f(input int lsb, input int val);
        return 21'(val) << lsb;
    endfunction

    localparam logic [20:0] PCW = f(20, 1), IORD = f(17, 1), MR = f(16, 1), MW = f(15, 1);
    localparam logic [20:0] IRW = f(14, 1), RW = f(13, 1), ASA = f(8, 1), ILL = f(0, 1);
    localparam logic [20:0] ADD = f(3, 3), IMM = f(6, 2);
    localparam logic [20:0] FETCH_WAIT = MR | f(6, 1) | ADD;
    localparam logic [20:0] FETCH_GO = FETCH_WAIT | IRW | PCW;
    localparam logic [20:0] DEC = f(6, 3) | ADD;
    localparam logic [20:0] MEMADR = ASA | IMM | ADD;
    localparam logic [20:0] MEMRD = MR | IORD;
    localparam logic [20:0] MEMWB = RW | f(9, 1);
    localparam logic [20:0] MEMWR = MW | IORD;
    localparam logic [20:0] REXE = ASA | f(3, 7);
    localparam logic [20:0] RWB = RW | f(11, 1);
    localparam logic [20:0] BRX = ASA | f(3, 2) | f(1, 1);
    localparam logic [20:0] JMP = PCW | f(1, 2);
    localparam logic [20:0] JAL = JMP | RW | f(11, 2) | f(9, 2);

    logic [20:0] act;
    assign act = {bus.pc_write, bus.branch_eq, bus.branch_ne, bus.iord, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                  bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal};

    logic [20:0] expQ[$];
    string       nameQ[$];
    int          passed = 0;
    int          total = 0;

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            logic [20:0] e;
            string       n;
            e = expQ.pop_front();
            n = nameQ.pop_front();
            total++;
            if (act === e) passed++;
            else $display("FAIL %s: got %b expected %b", n, act, e);
        end
    end

    task automatic drive(input logic rst, input logic [5:0] op, input logic mr,
                         input logic [20:0] e, input string n);
        reset = rst;
        bus.op = op;
        bus.mem_ready = mr;
        expQ.push_back(e);
        nameQ.push_back(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b1, 6'h00, 1'b1, '0, "reset0");
        drive(1'b1, 6'h00, 1'b1, '0, "reset1");
        // R-type, mem_ready low outside FETCH must be ignored
        drive(1'b0, 6'h00, 1'b1, FETCH_GO, "r_fetch");
        drive(1'b0, 6'h00, 1'b0, DEC, "r_decode");
        drive(1'b0, 6'h00, 1'b0, REXE, "r_exe");
        drive(1'b0, 6'h00, 1'b0, RWB, "r_wb");
        drive(1'b0, 6'h23, 1'b0, FETCH_WAIT, "lw_fetch_wait");
        drive(1'b0, 6'h23, 1'b1, FETCH_GO, "lw_fetch");
        drive(1'b0, 6'h23, 1'b1, DEC, "lw_decode");
        drive(1'b0, 6'h23, 1'b1, MEMADR, "lw_memadr");
        for (int i = 0; i < 3; i++) drive(1'b0, 6'h23, 1'b0, MEMRD, "lw_memrd_wait");
        drive(1'b0, 6'h23, 1'b1, MEMRD, "lw_memrd_done");
        drive(1'b0, 6'h23, 1'b1, MEMWB, "lw_memwb");
        drive(1'b0, 6'h2b, 1'b1, FETCH_GO, "sw_fetch");
        drive(1'b0, 6'h2b, 1'b1, DEC, "sw_decode");
        drive(1'b0, 6'h2b, 1'b1, MEMADR, "sw_memadr");
        drive(1'b0, 6'h2b, 1'b1, MEMWR, "sw_memwr");
        drive(1'b0, 6'h08, 1'b1, FETCH_GO, "addi_fetch");
        drive(1'b0, 6'h08, 1'b1, DEC, "addi_decode");
        drive(1'b0, 6'h08, 1'b1, ASA | IMM | f(3, 4), "addi_exe");
        drive(1'b0, 6'h08, 1'b1, ASA | IMM | f(3, 4) | RW, "addi_wb");
        drive(1'b0, 6'h0d, 1'b1, FETCH_GO, "ori_fetch");
        drive(1'b0, 6'h0d, 1'b1, DEC, "ori_decode");
        drive(1'b0, 6'h0d, 1'b1, ASA | IMM | f(3, 1), "ori_exe");
        drive(1'b0, 6'h0d, 1'b1, ASA | IMM | f(3, 1) | RW, "ori_wb");
        drive(1'b0, 6'h0f, 1'b1, FETCH_GO, "lui_fetch");
        drive(1'b0, 6'h0f, 1'b1, DEC, "lui_decode");
        drive(1'b0, 6'h0f, 1'b1, ASA | IMM | f(3, 5), "lui_exe");
        drive(1'b0, 6'h0f, 1'b1, ASA | IMM | f(3, 5) | RW, "lui_wb");
        drive(1'b0, 6'h04, 1'b1, FETCH_GO, "beq_fetch");
        drive(1'b0, 6'h04, 1'b1, DEC, "beq_decode");
        drive(1'b0, 6'h04, 1'b1, BRX | f(19, 1), "beq_br");
        drive(1'b0, 6'h05, 1'b1, FETCH_GO, "bne_fetch");
        drive(1'b0, 6'h05, 1'b1, DEC, "bne_decode");
        drive(1'b0, 6'h05, 1'b1, BRX | f(18, 1), "bne_br");
        drive(1'b0, 6'h02, 1'b1, FETCH_GO, "j_fetch");
        drive(1'b0, 6'h02, 1'b1, DEC, "j_decode");
        drive(1'b0, 6'h02, 1'b1, JMP, "j_jmp");
        drive(1'b0, 6'h3f, 1'b1, FETCH_GO, "ill_fetch");
        drive(1'b0, 6'h3f, 1'b1, DEC | ILL, "ill_decode");
        drive(1'b0, 6'h03, 1'b1, FETCH_GO, "jal_fetch");
`ifdef MC_JAL_EN
        drive(1'b0, 6'h03, 1'b1, DEC, "jal_decode");
        drive(1'b0, 6'h03, 1'b1, JAL, "jal_jal");
`else
        drive(1'b0, 6'h03, 1'b1, DEC | ILL, "jal_illegal");
`endif
        // reset while a store is waiting on memory
        drive(1'b0, 6'h2b, 1'b1, FETCH_GO, "rst_sw_fetch");
        drive(1'b0, 6'h2b, 1'b1, DEC, "rst_sw_decode");
        drive(1'b0, 6'h2b, 1'b0, MEMADR, "rst_sw_memadr");
        drive(1'b0, 6'h2b, 1'b0, MEMWR, "rst_sw_wait0");
        drive(1'b0, 6'h2b, 1'b0, MEMWR, "rst_sw_wait1");
        drive(1'b1, 6'h2b, 1'b0, '0, "rst_sw_reset");
        drive(1'b0, 6'h2b, 1'b0, FETCH_WAIT, "rst_sw_fetch_after");
        drive(1'b0, 6'h00, 1'b1, FETCH_GO, "post_fetch");
        drive(1'b0, 6'h00, 1'b1, DEC, "post_decode");
        @(negedge clk);
        #1;
        total++;
        if (expQ.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", expQ.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
